// File: rtl/alu_controller_if.sv
// Interface bundling the instruction handshake, ALU bus and status lines of alu_controller.
// master is the controller side; slave is the instruction source / ALU / observer side.
interface alu_controller_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  instrValid;
  logic [11:0]           instr;
  logic                  instrReady;
  logic [DATA_WIDTH-1:0] aluA;
  logic [DATA_WIDTH-1:0] aluB;
  logic [1:0]            aluControl;
  logic [DATA_WIDTH-1:0] aluResult;
  logic [1:0]            regSel;
  logic [DATA_WIDTH-1:0] regData;
  logic                  zeroFlag;
  logic                  done;
  logic                  error;

  modport master (
    input  instrValid, instr, aluResult, regSel,
    output instrReady, aluA, aluB, aluControl, regData, zeroFlag, done, error
  );

  modport slave (
    output instrValid, instr, aluResult, regSel,
    input  instrReady, aluA, aluB, aluControl, regData, zeroFlag, done, error
  );
endinterface

// File: rtl/alu_controller.sv
// Multi-cycle execute controller for the 8-bit ALU: decodes instructions, owns a
// 4-entry register file and the architectural zero flag.
//
//   state  | meaning
//   IDLE   | ready for a new instruction
//   DECODE | read operands / LDI write / flag a reserved kind
//   EXEC   | capture ALU result, write back, update zero flag
//   DONE   | one-cycle done (and error) pulse
module alu_controller #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic              clk,
  input logic              rst_n,
  alu_controller_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] K_ALU = 2'b00;
  localparam logic [1:0] K_LDI = 2'b01;
  localparam logic [1:0] K_CMP = 2'b10;

  state_t                         state_q, state_d;
  logic [11:0]                    instr_q, instr_d;
  logic [3:0][DATA_WIDTH-1:0]     regs_q, regs_d;
  logic [DATA_WIDTH-1:0]          alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]          alu_b_q, alu_b_d;
  logic [1:0]                     alu_ctrl_q, alu_ctrl_d;
  logic [DATA_WIDTH-1:0]          reg_data_q, reg_data_d;
  logic                           zero_q, zero_d;
  logic                           err_pend_q, err_pend_d;

  logic [1:0]            kind, op, dst, src_a, src_b, ldi_dst;
  logic [DATA_WIDTH-1:0] imm;
  logic                  unused_instr_bits;

  assign kind    = instr_q[11:10];
  assign op      = instr_q[9:8];
  assign dst     = instr_q[7:6];
  assign src_a   = instr_q[5:4];
  assign src_b   = instr_q[3:2];
  assign ldi_dst = instr_q[9:8];
  assign imm     = instr_q[7:0];
  assign unused_instr_bits = ^instr_q[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      regs_q     <= {4{RESET_VALUE}};
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= 2'b00;
      reg_data_q <= '0;
      zero_q     <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      regs_q     <= regs_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      reg_data_q <= reg_data_d;
      zero_q     <= zero_d;
      err_pend_q <= err_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    regs_d     = regs_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    zero_d     = zero_q;
    err_pend_d = err_pend_q;
    // Read-out samples the pre-write contents, giving one cycle of latency.
    reg_data_d = regs_q[bus.regSel];

    case (state_q)
      S_IDLE: begin
        if (bus.instrValid) begin
          instr_d = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (kind)
          K_ALU, K_CMP: begin
            alu_a_d    = regs_q[src_a];
            alu_b_d    = regs_q[src_b];
            alu_ctrl_d = op;
            state_d    = S_EXEC;
          end
          K_LDI: begin
            regs_d[ldi_dst] = imm;
            state_d         = S_DONE;
          end
          default: begin
            err_pend_d = 1'b1;
            state_d    = S_DONE;
          end
        endcase
      end
      S_EXEC: begin
        zero_d = (bus.aluResult == '0);
        if (kind == K_ALU) regs_d[dst] = bus.aluResult;
        state_d = S_DONE;
      end
      default: begin
        err_pend_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  assign bus.instrReady = (state_q == S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.error      = (state_q == S_DONE) && err_pend_q;
  assign bus.aluA       = alu_a_q;
  assign bus.aluB       = alu_b_q;
  assign bus.aluControl = alu_ctrl_q;
  assign bus.regData    = reg_data_q;
  assign bus.zeroFlag   = zero_q;

endmodule

// File: tb/tb_alu_controller.sv
// Bench for alu_controller: a latency-level reference model checked every cycle,
// plus directed instruction sequences with hand-computed literal expectations.
module tb_alu_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_controller_if #(.DATA_WIDTH(8)) bus();

  alu_controller #(.DATA_WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // ALU stand-in driven from the controller's registered operands
  always_comb bus.aluResult = alu_f(bus.aluControl, bus.aluA, bus.aluB);

  int n_vec = 0;
  int n_err = 0;
  bit run = 1'b0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted instruction's effects appear in the cycle its done pulses,
  // 3 cycles after accept for ALU/CMP and 2 for LDI/reserved.
  logic [7:0] m_regs [4];
  logic       m_zero, m_ready, m_done, m_err;
  logic [7:0] m_regdata;
  int         m_cnt;
  logic [1:0] p_dst;
  logic [7:0] p_res;
  logic       p_wr, p_flag, p_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
      m_zero <= 1'b0; m_ready <= 1'b1; m_done <= 1'b0; m_err <= 1'b0;
      m_regdata <= 8'h00; m_cnt <= 0;
      p_dst <= 2'd0; p_res <= 8'h00; p_wr <= 1'b0; p_flag <= 1'b0; p_err <= 1'b0;
    end else begin
      m_regdata <= m_regs[bus.regSel];
      if (m_done) begin
        m_done <= 1'b0; m_err <= 1'b0; m_ready <= 1'b1;
      end else if (m_ready) begin
        if (bus.instrValid) begin
          m_ready <= 1'b0;
          case (bus.instr[11:10])
            2'b00, 2'b10: begin
              p_res  <= alu_f(bus.instr[9:8], m_regs[bus.instr[5:4]], m_regs[bus.instr[3:2]]);
              p_dst  <= bus.instr[7:6];
              p_wr   <= (bus.instr[11:10] == 2'b00);
              p_flag <= 1'b1; p_err <= 1'b0; m_cnt <= 2;
            end
            2'b01: begin
              p_res <= bus.instr[7:0]; p_dst <= bus.instr[9:8];
              p_wr <= 1'b1; p_flag <= 1'b0; p_err <= 1'b0; m_cnt <= 1;
            end
            default: begin
              p_wr <= 1'b0; p_flag <= 1'b0; p_err <= 1'b1; m_cnt <= 1;
            end
          endcase
        end
      end else if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_err  <= p_err;
        if (p_wr)   m_regs[p_dst] <= p_res;
        if (p_flag) m_zero <= (p_res == 8'h00);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      if (rst_n) check("instrReady", bus.instrReady, m_ready);
      check("done", bus.done, m_done);
      check("error", bus.error, m_err);
      check("regData", bus.regData, m_regdata);
      check("zeroFlag", bus.zeroFlag, m_zero);
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.instrReady && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      n_vec++; n_err++;
      $display("FAIL %s: instrReady never rose within 20 cycles", name);
    end
  endtask

  task automatic issue(input string name, input logic [11:0] w, input int exp_lat, output logic err_seen);
    int c;
    @(negedge clk);
    bus.instrValid = 1'b1;
    bus.instr      = w;
    wait_ready(name);
    @(posedge clk);
    @(negedge clk);
    bus.instrValid = 1'b0;
    c = 1;
    while (!bus.done && c < 20) begin @(negedge clk); c++; end
    err_seen = bus.error;
    check({name, "_latency"}, c, exp_lat);
  endtask

  task automatic peek(input string name, input logic [1:0] r, input logic [7:0] exp);
    @(negedge clk);
    bus.regSel = r;
    @(negedge clk);
    check(name, bus.regData, exp);
  endtask

  logic        e;
  logic [11:0] seq [3];
  int          acc [3];

  initial begin
    bus.instrValid = 1'b0;
    bus.instr      = 12'h000;
    bus.regSel     = 2'd0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.instrReady, 1'b1);
    check("rst_zero", bus.zeroFlag, 1'b0);
    check("rst_regData", bus.regData, 8'h00);

    // LDI r0=05, r1=03
    issue("ldi_r0", 12'h405, 2, e); check("ldi_r0_err", e, 1'b0);
    issue("ldi_r1", 12'h503, 2, e);
    peek("r0_is_05", 2'd0, 8'h05);
    peek("r1_is_03", 2'd1, 8'h03);
    check("zero_after_ldi", bus.zeroFlag, 1'b0);

    // add r2=r0+r1, sub r3=r1-r0 (wraps)
    issue("add_r2", 12'h084, 3, e);
    peek("r2_is_08", 2'd2, 8'h08);
    check("zero_add", bus.zeroFlag, 1'b0);
    issue("sub_r3", 12'h1D0, 3, e);
    peek("r3_is_fe", 2'd3, 8'hFE);

    // CMP r0-r0 sets flag without writeback; or clears it
    issue("cmp_r0", 12'h900, 3, e);
    check("zero_cmp", bus.zeroFlag, 1'b1);
    peek("r0_kept", 2'd0, 8'h05);
    issue("or_r2", 12'h384, 3, e);
    check("zero_or", bus.zeroFlag, 1'b0);
    peek("r2_is_07", 2'd2, 8'h07);

    // aliasing and a zero result
    issue("ldi_r0_ff", 12'h4FF, 2, e);
    issue("add_alias", 12'h000, 3, e);
    peek("r0_is_fe", 2'd0, 8'hFE);
    issue("ldi_r3_0", 12'h700, 2, e);
    issue("and_r1", 12'h24C, 3, e);
    check("zero_and", bus.zeroFlag, 1'b1);
    peek("r1_is_00", 2'd1, 8'h00);

    // reserved kind
    issue("reserved", 12'hC00, 2, e);
    check("reserved_err", e, 1'b1);
    check("reserved_zero", bus.zeroFlag, 1'b1);
    peek("reserved_r0", 2'd0, 8'hFE);

    // back-to-back with instrValid held high
    seq[0] = 12'h084; seq[1] = 12'h1D0; seq[2] = 12'h384;
    @(negedge clk);
    bus.instrValid = 1'b1;
    bus.instr      = seq[0];
    for (int i = 0; i < 3; i++) begin
      wait_ready("b2b");
      acc[i] = cyc;
      @(posedge clk);
      @(negedge clk);
      if (i < 2) bus.instr = seq[i+1];
      else       bus.instrValid = 1'b0;
    end
    check("b2b_gap1", acc[1] - acc[0], 4);
    check("b2b_gap2", acc[2] - acc[1], 4);
    repeat (3) @(negedge clk);
    peek("b2b_r3", 2'd3, 8'h02);
    peek("b2b_r2", 2'd2, 8'hFE);

    // reset during EXEC aborts the write
    issue("ldi_r0_5", 12'h405, 2, e);
    issue("ldi_r1_3", 12'h503, 2, e);
    @(negedge clk);
    bus.instrValid = 1'b1;
    bus.instr      = 12'h084;
    wait_ready("abort");
    @(posedge clk);
    @(negedge clk);
    bus.instrValid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort_no_done", bus.done, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", bus.instrReady, 1'b1);
    peek("abort_r2", 2'd2, 8'h00);
    peek("abort_r0", 2'd0, 8'h00);
    repeat (2) @(negedge clk);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_controller.md
Name: alu_controller

Overview:
- Multi-cycle execute controller that sits on the master side of the 8-bit ALU: accepts instructions over a valid/ready handshake, reads a 4-entry register file, drives ALU operands/control, captures the ALU result and writes it back.
- Owns the architectural zero flag: the flag is computed locally from the captured ALU result, and the ALU's own zero output is not used.
- Placed between the instruction source and the ALU in the processor datapath.

Parameters:
- DATA_WIDTH, 8, ALU operand/register width. Only 8 is supported.
- RESET_VALUE, 8'h00, reset value of every register-file entry.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instrValid  input  1  instruction present on instr
- instr  input  12  instruction word (format below)
- instrReady  output  1  controller can accept an instruction
- aluA  output  8  ALU operand A (registered)
- aluB  output  8  ALU operand B (registered)
- aluControl  output  2  ALU operation: 00 add, 01 sub, 10 and, 11 or (registered)
- aluResult  input  8  ALU result (combinational from aluA/aluB/aluControl)
- regSel  input  2  register-file read-out select
- regData  output  8  registered copy of reg[regSel]
- zeroFlag  output  1  architectural zero flag
- done  output  1  one-cycle pulse per completed instruction
- error  output  1  one-cycle pulse, coincident with done, for a reserved instruction

Behaviour:
- Instruction format, kind = instr[11:10]:
  - 00 ALU: op = [9:8], dst = [7:6], srcA = [5:4], srcB = [3:2]; [1:0] ignored.
  - 01 LDI: dst = [9:8], imm = [7:0].
  - 10 CMP: same fields as ALU, but no writeback; only the flag is updated.
  - 11 reserved.
- Reset (async, rst_n = 0):
  - State = IDLE; all regs = RESET_VALUE.
  - aluA = aluB = 0, aluControl = 00, regData = 0, zeroFlag = 0, done = 0, error = 0.
  - instrReady = 1 after reset deasserts.
  - Reset mid-instruction aborts it: no writeback, no done pulse.
- FSM states: IDLE, DECODE, EXEC, DONE.
  - IDLE: instrReady = 1. On instrValid & instrReady, latch instr and go to DECODE. instrReady is 0 in every other state, and instr is ignored there.
  - DECODE, kind ALU/CMP: aluA <= reg[srcA], aluB <= reg[srcB], aluControl <= op; go to EXEC.
  - DECODE, kind LDI: reg[dst] <= imm; go to DONE. zeroFlag is unchanged.
  - DECODE, kind reserved: set the error-pending bit; go to DONE. No register or flag change.
  - EXEC: sample aluResult. zeroFlag <= (aluResult == 0). For ALU, reg[dst] <= aluResult; for CMP, no write. Go to DONE.
  - DONE: done = 1 for exactly one cycle; error = 1 if error-pending, then clear it; go to IDLE.
- Timing for an ALU/CMP instruction accepted on edge k:
  - DECODE in cycle k+1, EXEC in k+2, DONE in k+3, instrReady = 1 again in k+4.
  - Writeback and zeroFlag are visible from cycle k+3.
- LDI and reserved instructions skip EXEC: done in cycle k+2.
- Maximum throughput:
  - ALU/CMP: 1 instruction per 4 cycles.
  - LDI: 1 instruction per 3 cycles.
- aluA, aluB and aluControl hold their last values outside DECODE/EXEC.
- Arithmetic: add and sub wrap modulo 256. No carry or borrow output.
- srcA, srcB and dst may alias; operands are read in DECODE, before the EXEC write.
- regData <= reg[regSel] every cycle, so it has 1-cycle latency. A write at edge e is visible on regData after edge e+1.
- instrValid held high while instrReady = 0: the instruction is accepted on the first IDLE cycle, and the source must hold instr stable until then.

Test Plan:
- Reset, then LDI r0=8'h05, LDI r1=8'h03 -> done pulses at k+2; regData(r0)=05 and regData(r1)=03; zeroFlag=0; instrReady low for 2 cycles after each accept.
- ALU add r2=r0+r1 (05+03), then sub r3=r1-r0 -> r2=08 with zeroFlag=0; r3=8'hFE (wrap) with zeroFlag=0; done exactly 3 cycles after each accept.
- CMP sub r0-r0 with r0=05 -> zeroFlag=1, r0 unchanged; a following ALU or r0|r1 -> zeroFlag=0, r2=07.
- Aliasing: r0=8'hFF, ALU add r0=r0+r0 -> r0=8'hFE; and with an r3=00 operand -> result 00 and zeroFlag=1.
- Reserved kind 11 -> done and error both pulse at k+2; registers and flag unchanged. instrValid held high continuously -> back-to-back accepts exactly every 4 cycles for ALU ops.
- Assert rst_n low during EXEC of r2=r0+r1 -> r2 returns to 00, no done pulse, and instrReady=1 one cycle after release.
